morse_stream_decoder: RTL and testbench
=======================================

# morse_stream_decoder

Parametrised successor to the fixed-width capture/decode path: turns one debounced Morse key input into a stream of decoded character codes with a valid/ready handshake and an internal character FIFO, instead of a fixed MAX_CHARS word register. Sits between CONF (timing values) and any consumer, such as a scrolling CHAR2SEG display driver or UART. Adds keying polarity selection, symbol-count overflow detection, automatic word-space tokens and FIFO overflow reporting.

## Interface
Parameters:
- CNT_W, `PULSE_CNT_W: width of duration counters and timing inputs
- CHAR_W, `CHAR_W (6): character code width
- MAX_SYMS, 6: maximum dits/dahs per character
- FIFO_DEPTH, 8: character FIFO entries, power of 2, ≥2
- ACTIVE_LOW, 1: 1 = key pressed when signal is 0
- SYNC_STAGES, 2: input synchroniser flops, ≥2

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- ce  in  1  capture enable
- signal  in  1  raw key input (asynchronous)
- dit_time, dah_time, word_time, tol_time  in  CNT_W each  nominal durations and tolerance, in cycles
- char_valid  out  1  FIFO non-empty
- char_ready  in  1  consumer accepts head entry
- char_code  out  CHAR_W  head entry
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
- error  out  1  one-cycle pulse on a malformed character
- overflow  out  1  sticky; cleared only by rst

## Operation
- Input path: SYNC_STAGES flops, then XOR with ACTIVE_LOW to give `mark`. Edge detect uses one extra registered copy.
- Duration counter: CNT_W bits, saturating at all-ones, restarts at 1 on every edge of `mark`.
- Thresholds are computed at CNT_W+1 bits: lo(x) = x − tol, clamped at 0; hi(x) = x + tol. Dit when lo(dit) ≤ len ≤ hi(dit). Dah when lo(dah) ≤ len ≤ hi(dah). If both windows match, dit wins. Otherwise the mark is bad.
- FSM states:
  - IDLE: on mark rise → MARK.
  - MARK: on fall, classify and append the symbol (dit=0, dah=1, shifted into LSB, sym_cnt++) → GAP. A bad mark or sym_cnt = MAX_SYMS sets the bad_char flag.
  - GAP: mark rise → MARK (intra-character gap). Counter reaching lo(dah) → push char → CHAR_DONE.
  - CHAR_DONE: mark rise → MARK. Counter reaching lo(word) → push space → IDLE.
- Character code comes from sub-module morse_sym2char(sym_cnt, sym_bits):
  - digits 0–9 → 0–9; A–Z → 10–35; space = 36
  - unmapped patterns and bad_char → 63 (`CHAR_UNKNOWN)
  - a char push with code 63 also pulses error
- Pushing a char clears sym_bits, sym_cnt and bad_char.
- FIFO: pop when char_valid & char_ready. Push when full without a same-cycle pop → entry dropped, overflow = 1. Push and pop in the same cycle while full → both succeed, level unchanged. Push and pop while empty → push only.
- ce = 0: FSM, counter and symbol register hold, and no pushes occur. The synchroniser still shifts. The FIFO read side keeps operating.

## Timing
- Reset values: char_valid = 0, char_code = 0, fifo_level = 0, error = 0, overflow = 0; FSM in IDLE; counters and FIFO pointers 0.
- rst mid-character discards the partial symbols. The first full character after reset decodes normally.
- Latency from a signal edge to the FSM seeing it: SYNC_STAGES + 1 cycles.
- The push happens on the cycle the counter equals the threshold. char_valid and char_code are registered and appear 1 cycle after the push.
- error is asserted in the same cycle as char_valid.
- char_code is stable while char_valid & !char_ready.
- Throughput: 1 pop per cycle.

## Structure
- defines.vh gains `CHAR_SPACE (36), `CHAR_UNKNOWN (63) and the symbol encoding.
- FSM state encodings stay local to the module.
- One sub-module: morse_sym2char, combinational lookup table.
- The FIFO is written inline; it is not a separate module.

## Test plan
Use dit=4, dah=12, word=28, tol=1, ACTIVE_LOW=0.
1. Mark 4, gap 4, mark 12, then idle 40 → codes 10 ('A') then 36, in order; error never asserts.
2. Single mark of 8 cycles, then idle 40 → code 63 with error pulse, then 36.
3. Seven dits with gap 4 each → code 63 and error (symbol overflow).
4. char_ready = 0 while 9 chars are sent → fifo_level = 8, overflow = 1. Draining returns the first 8 codes in order, then char_valid = 0.
5. rst pulsed mid-dah → all outputs 0 next cycle; the following "E" (single dit) yields code 14.
6. Two cases:
   - ACTIVE_LOW = 1, same stimulus as scenario 1 inverted → identical output.
   - ce = 0 held for 50 cycles in GAP → no push; after ce returns the character completes normally.

Source files
------------

// File: rtl/morse_stream_decoder_pkg.sv
// Shared constants and types for the Morse stream decoder.
package morse_stream_decoder_pkg;

    localparam int PULSE_CNT_W  = 16;
    localparam int CHAR_W_DEF   = 6;

    // Character codes: digits 0-9, letters A-Z at 10-35.
    localparam int CHAR_SPACE   = 36;
    localparam int CHAR_UNKNOWN = 63;

    // Symbol encoding shifted into the symbol register LSB.
    localparam logic SYM_DIT = 1'b0;
    localparam logic SYM_DAH = 1'b1;

    typedef enum logic [1:0] {
        MK_DIT,
        MK_DAH,
        MK_BAD
    } mark_class_t;

endpackage

// File: rtl/morse_stream_decoder_if.sv
// Character stream handshake between the decoder and its consumer.
interface morse_stream_decoder_if #(
    parameter int CHAR_W = 6
);
    logic              char_valid;
    logic              char_ready;
    logic [CHAR_W-1:0] char_code;

    modport master (output char_valid, output char_code, input char_ready);
    modport slave  (input char_valid, input char_code, output char_ready);
endinterface

// File: rtl/morse_stream_decoder_sym2char.sv
// Combinational lookup from a dit/dah pattern to a character code.
// The first keyed symbol sits in the most significant used bit.
module morse_stream_decoder_sym2char
    import morse_stream_decoder_pkg::*;
#(
    parameter int MAX_SYMS = 6,
    parameter int CHAR_W   = CHAR_W_DEF,
    localparam int SC_W    = $clog2(MAX_SYMS + 1)
) (
    input  logic [SC_W-1:0]     sym_cnt,
    input  logic [MAX_SYMS-1:0] sym_bits,
    input  logic                bad_char,
    output logic [CHAR_W-1:0]   code
);

    logic [4:0]          b;
    logic [MAX_SYMS-1:0] upper;
    int                  c;

    assign b     = 5'(sym_bits);
    assign upper = sym_bits >> 5;

    // Table lookup; anything unmapped or flagged bad decodes as unknown.
    always_comb begin
        c = CHAR_UNKNOWN;
        case (int'(sym_cnt))
            1: c = b[0] ? 29 : 14;
            2: case (b[1:0])
                   2'b00: c = 18;
                   2'b01: c = 10;
                   2'b10: c = 23;
                   default: c = 22;
               endcase
            3: case (b[2:0])
                   3'b000: c = 28;
                   3'b001: c = 30;
                   3'b010: c = 27;
                   3'b011: c = 32;
                   3'b100: c = 13;
                   3'b101: c = 20;
                   3'b110: c = 16;
                   default: c = 24;
               endcase
            4: case (b[3:0])
                   4'b0000: c = 17;
                   4'b0001: c = 31;
                   4'b0010: c = 15;
                   4'b0100: c = 21;
                   4'b0110: c = 25;
                   4'b0111: c = 19;
                   4'b1000: c = 11;
                   4'b1001: c = 33;
                   4'b1010: c = 12;
                   4'b1011: c = 34;
                   4'b1100: c = 35;
                   4'b1101: c = 26;
                   default: c = CHAR_UNKNOWN;
               endcase
            5: case (b)
                   5'b11111: c = 0;
                   5'b01111: c = 1;
                   5'b00111: c = 2;
                   5'b00011: c = 3;
                   5'b00001: c = 4;
                   5'b00000: c = 5;
                   5'b10000: c = 6;
                   5'b11000: c = 7;
                   5'b11100: c = 8;
                   5'b11110: c = 9;
                   default:  c = CHAR_UNKNOWN;
               endcase
            default: c = CHAR_UNKNOWN;
        endcase
        if (bad_char || (upper != '0)) begin
            c = CHAR_UNKNOWN;
        end
    end

    assign code = CHAR_W'(c);

endmodule

// File: rtl/morse_stream_decoder.sv
// Morse key decoder: synchroniser, duration counter, symbol FSM and
// character FIFO with valid/ready output.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | no character in progress, waiting for a mark
// MARK      | key pressed, timing the mark
// GAP       | key released inside a character
// CHAR_DONE | character pushed, waiting for word-space time
module morse_stream_decoder
    import morse_stream_decoder_pkg::*;
#(
    parameter int CNT_W       = PULSE_CNT_W,
    parameter int CHAR_W      = CHAR_W_DEF,
    parameter int MAX_SYMS    = 6,
    parameter int FIFO_DEPTH  = 8,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter int SYNC_STAGES = 2,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   signal,
    input  logic [CNT_W-1:0]       dit_time,
    input  logic [CNT_W-1:0]       dah_time,
    input  logic [CNT_W-1:0]       word_time,
    input  logic [CNT_W-1:0]       tol_time,
    morse_stream_decoder_if.master chars,
    output logic [LVL_W-1:0]       fifo_level,
    output logic                   error,
    output logic                   overflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_GAP,
        ST_CHAR_DONE
    } state_t;

    localparam int   TW       = CNT_W + 1;
    localparam int   SC_W     = $clog2(MAX_SYMS + 1);
    localparam int   AW       = $clog2(FIFO_DEPTH);
    localparam logic IDLE_LVL = ACTIVE_LOW;

    function automatic logic [TW-1:0] lo_of(input logic [CNT_W-1:0] x,
                                            input logic [CNT_W-1:0] t);
        return (x > t) ? (TW'(x) - TW'(t)) : '0;
    endfunction

    function automatic logic [TW-1:0] hi_of(input logic [CNT_W-1:0] x,
                                            input logic [CNT_W-1:0] t);
        return TW'(x) + TW'(t);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   mark, mark_d, rise, fall;
    logic [CNT_W-1:0]       cnt;
    logic [TW-1:0]          cnt_x;
    mark_class_t            cls;

    state_t                 state, state_nxt;
    logic [MAX_SYMS-1:0]    sym_bits, sym_bits_nxt;
    logic [SC_W-1:0]        sym_cnt, sym_cnt_nxt;
    logic                   bad_char, bad_char_nxt;
    logic                   push, push_char, push_eff, push_ok, pop, full;
    logic [CHAR_W-1:0]      push_code, lut_code;

    logic [CHAR_W-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [LVL_W-1:0]       level;

    // Input synchroniser; reset to the idle key level so no false mark appears.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= {SYNC_STAGES{IDLE_LVL}};
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
    end

    assign mark = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;
    assign rise = mark & ~mark_d;
    assign fall = ~mark & mark_d;

    // Edge-detect copy and duration counter; both freeze while ce is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            mark_d <= 1'b0;
            cnt    <= '0;
        end else if (ce) begin
            mark_d <= mark;
            if (rise || fall)    cnt <= CNT_W'(1);
            else if (cnt != '1)  cnt <= cnt + 1'b1;
        end
    end

    assign cnt_x = {1'b0, cnt};

    // Classify the mark length; the dit window takes priority on overlap.
    always_comb begin
        cls = MK_BAD;
        if (cnt_x >= lo_of(dit_time, tol_time) && cnt_x <= hi_of(dit_time, tol_time))
            cls = MK_DIT;
        else if (cnt_x >= lo_of(dah_time, tol_time) && cnt_x <= hi_of(dah_time, tol_time))
            cls = MK_DAH;
    end

    morse_stream_decoder_sym2char #(
        .MAX_SYMS (MAX_SYMS),
        .CHAR_W   (CHAR_W)
    ) u_sym2char (
        .sym_cnt  (sym_cnt),
        .sym_bits (sym_bits),
        .bad_char (bad_char),
        .code     (lut_code)
    );

    // FSM next-state, symbol accumulation and push requests.
    always_comb begin
        state_nxt    = state;
        sym_bits_nxt = sym_bits;
        sym_cnt_nxt  = sym_cnt;
        bad_char_nxt = bad_char;
        push         = 1'b0;
        push_char    = 1'b0;
        push_code    = lut_code;
        case (state)
            ST_IDLE: begin
                if (rise) state_nxt = ST_MARK;
            end
            ST_MARK: begin
                if (fall) begin
                    if (cls == MK_BAD || sym_cnt == SC_W'(MAX_SYMS)) begin
                        bad_char_nxt = 1'b1;
                    end else begin
                        sym_bits_nxt = {sym_bits[MAX_SYMS-2:0],
                                        (cls == MK_DAH) ? SYM_DAH : SYM_DIT};
                        sym_cnt_nxt  = sym_cnt + 1'b1;
                    end
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (rise) begin
                    state_nxt = ST_MARK;
                end else if (cnt_x == lo_of(dah_time, tol_time)) begin
                    push         = 1'b1;
                    push_char    = 1'b1;
                    sym_bits_nxt = '0;
                    sym_cnt_nxt  = '0;
                    bad_char_nxt = 1'b0;
                    state_nxt    = ST_CHAR_DONE;
                end
            end
            ST_CHAR_DONE: begin
                if (rise) begin
                    state_nxt = ST_MARK;
                end else if (cnt_x == lo_of(word_time, tol_time)) begin
                    push      = 1'b1;
                    push_code = CHAR_W'(CHAR_SPACE);
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM and symbol registers; hold while capture is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sym_bits <= '0;
            sym_cnt  <= '0;
            bad_char <= 1'b0;
        end else if (ce) begin
            state    <= state_nxt;
            sym_bits <= sym_bits_nxt;
            sym_cnt  <= sym_cnt_nxt;
            bad_char <= bad_char_nxt;
        end
    end

    assign push_eff = push & ce;
    assign full     = (level == LVL_W'(FIFO_DEPTH));
    assign pop      = chars.char_valid & chars.char_ready;
    assign push_ok  = push_eff & (~full | pop);

    // Character FIFO; a full FIFO only accepts a push when it pops the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_code;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Error pulse lines up with the pushed entry becoming visible; overflow is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            error    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            error <= push_eff & push_char & (push_code == CHAR_W'(CHAR_UNKNOWN));
            if (push_eff && full && !pop) overflow <= 1'b1;
        end
    end

    assign chars.char_valid = (level != '0);
    assign chars.char_code  = chars.char_valid ? mem[rd_ptr] : '0;
    assign fifo_level       = level;

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Directed bench: two decoders (active-high and active-low keying) share
// timing inputs; popped codes and error pulses are logged at the falling edge.
module tb_morse_stream_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce  = 1'b1;
    logic        key = 1'b0;
    logic        use_b = 1'b0;
    logic        sig_a, sig_b;
    logic [15:0] dit_t = 16'd4, dah_t = 16'd12, word_t = 16'd28, tol_t = 16'd1;
    logic [3:0]  lvl_a, lvl_b;
    logic        err_a, err_b, ovf_a, ovf_b;

    int total = 0;
    int bad   = 0;
    int qa[$];
    int qb[$];
    int err_cnt_a = 0, err_cnt_b = 0;
    int err_misaligned = 0;
    int err_code = -1;

    always #5 clk = ~clk;

    assign sig_a = use_b ? 1'b0 : key;
    assign sig_b = use_b ? ~key : 1'b1;

    morse_stream_decoder_if #(.CHAR_W(6)) ifa ();
    morse_stream_decoder_if #(.CHAR_W(6)) ifb ();

    morse_stream_decoder #(.CNT_W(16), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .signal(sig_a),
        .dit_time(dit_t), .dah_time(dah_t), .word_time(word_t), .tol_time(tol_t),
        .chars(ifa), .fifo_level(lvl_a), .error(err_a), .overflow(ovf_a)
    );

    morse_stream_decoder #(.CNT_W(16), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .signal(sig_b),
        .dit_time(dit_t), .dah_time(dah_t), .word_time(word_t), .tol_time(tol_t),
        .chars(ifb), .fifo_level(lvl_b), .error(err_b), .overflow(ovf_b)
    );

    // Log pops and error pulses away from the active edge.
    always @(negedge clk) begin
        if (ifa.char_valid && ifa.char_ready) qa.push_back(int'(ifa.char_code));
        if (ifb.char_valid && ifb.char_ready) qb.push_back(int'(ifb.char_code));
        if (err_a) begin
            err_cnt_a++;
            err_code = int'(ifa.char_code);
            if (!ifa.char_valid) err_misaligned++;
        end
        if (err_b) err_cnt_b++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        qa.delete();
        qb.delete();
        err_cnt_a = 0;
        err_cnt_b = 0;
        err_misaligned = 0;
        err_code = -1;
    endtask

    // Key n symbols (MSB first) and leave gap_end idle cycles after the last.
    task automatic send_char(input int n, input logic [4:0] bits, input int gap_end);
        for (int i = n - 1; i >= 0; i--) begin
            key = 1'b1;
            wait_cyc(bits[i] ? 12 : 4);
            key = 1'b0;
            wait_cyc((i == 0) ? gap_end : 4);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(1);
        total++; if (ifa.char_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", ifa.char_valid); end
        total++; if (ifa.char_code !== 6'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", ifa.char_code); end
        total++; if (lvl_a !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", lvl_a); end
        total++; if (err_a !== 1'b0 || ovf_a !== 1'b0) begin bad++; $display("FAIL reset_err_ovf got=%0b%0b exp=00", err_a, ovf_a); end
        total++; if (ifb.char_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_b got=%0b exp=0", ifb.char_valid); end
    endtask

    task automatic test_letter_a();
        clear_logs();
        send_char(2, 5'b00001, 40);
        total++; if (qa.size() !== 2) begin bad++; $display("FAIL a_count got=%0d exp=2", qa.size()); end
        total++; if (qa.size() < 1 || qa[0] !== 10) begin bad++; $display("FAIL a_code got=%0d exp=10", (qa.size() > 0) ? qa[0] : -1); end
        total++; if (qa.size() < 2 || qa[1] !== 36) begin bad++; $display("FAIL a_space got=%0d exp=36", (qa.size() > 1) ? qa[1] : -1); end
        total++; if (err_cnt_a !== 0) begin bad++; $display("FAIL a_no_error got=%0d exp=0", err_cnt_a); end
        total++; if (qb.size() !== 0) begin bad++; $display("FAIL a_b_quiet got=%0d exp=0", qb.size()); end
    endtask

    task automatic test_bad_mark();
        clear_logs();
        key = 1'b1;
        wait_cyc(8);
        key = 1'b0;
        wait_cyc(40);
        total++; if (qa.size() < 1 || qa[0] !== 63) begin bad++; $display("FAIL bad_code got=%0d exp=63", (qa.size() > 0) ? qa[0] : -1); end
        total++; if (qa.size() < 2 || qa[1] !== 36) begin bad++; $display("FAIL bad_space got=%0d exp=36", (qa.size() > 1) ? qa[1] : -1); end
        total++; if (err_cnt_a !== 1) begin bad++; $display("FAIL bad_err_pulses got=%0d exp=1", err_cnt_a); end
        total++; if (err_misaligned !== 0 || err_code !== 63) begin bad++; $display("FAIL bad_err_align got=%0d/%0d exp=0/63", err_misaligned, err_code); end
    endtask

    task automatic test_sym_overflow();
        clear_logs();
        for (int i = 0; i < 7; i++) begin
            key = 1'b1;
            wait_cyc(4);
            key = 1'b0;
            wait_cyc((i == 6) ? 40 : 4);
        end
        total++; if (qa.size() !== 2) begin bad++; $display("FAIL symovf_count got=%0d exp=2", qa.size()); end
        total++; if (qa.size() < 1 || qa[0] !== 63) begin bad++; $display("FAIL symovf_code got=%0d exp=63", (qa.size() > 0) ? qa[0] : -1); end
        total++; if (err_cnt_a !== 1) begin bad++; $display("FAIL symovf_err got=%0d exp=1", err_cnt_a); end
    endtask

    task automatic test_fifo_overflow();
        int exp_codes[8] = '{14, 29, 18, 10, 23, 22, 28, 30};
        clear_logs();
        ifa.char_ready = 1'b0;
        send_char(1, 5'b00000, 15);
        send_char(1, 5'b00001, 15);
        send_char(2, 5'b00000, 15);
        send_char(2, 5'b00001, 15);
        send_char(2, 5'b00010, 15);
        send_char(2, 5'b00011, 15);
        send_char(3, 5'b00000, 15);
        send_char(3, 5'b00001, 15);
        send_char(3, 5'b00010, 40);
        total++; if (lvl_a !== 4'd8) begin bad++; $display("FAIL fifo_full_level got=%0d exp=8", lvl_a); end
        total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL fifo_overflow got=%0b exp=1", ovf_a); end
        total++; if (ifa.char_code !== 6'd14) begin bad++; $display("FAIL fifo_head_held got=%0d exp=14", ifa.char_code); end
        ifa.char_ready = 1'b1;
        wait_cyc(12);
        total++; if (qa.size() !== 8) begin bad++; $display("FAIL fifo_drain_count got=%0d exp=8", qa.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (qa.size() <= i || qa[i] !== exp_codes[i]) begin
                bad++;
                $display("FAIL fifo_drain_%0d got=%0d exp=%0d", i, (qa.size() > i) ? qa[i] : -1, exp_codes[i]);
            end
        end
        total++; if (ifa.char_valid !== 1'b0 || lvl_a !== 4'd0) begin bad++; $display("FAIL fifo_empty got=%0b/%0d exp=0/0", ifa.char_valid, lvl_a); end
        total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL fifo_ovf_sticky got=%0b exp=1", ovf_a); end
    endtask

    task automatic test_reset_mid_char();
        clear_logs();
        ifa.char_ready = 1'b0;
        send_char(1, 5'b00000, 15);
        key = 1'b1;
        wait_cyc(6);
        total++; if (lvl_a !== 4'd1) begin bad++; $display("FAIL rstmid_pre_level got=%0d exp=1", lvl_a); end
        rst = 1'b1;
        key = 1'b0;
        wait_cyc(1);
        rst = 1'b0;
        total++; if (ifa.char_valid !== 1'b0 || ifa.char_code !== 6'd0) begin bad++; $display("FAIL rstmid_out got=%0b/%0d exp=0/0", ifa.char_valid, ifa.char_code); end
        total++; if (lvl_a !== 4'd0 || err_a !== 1'b0 || ovf_a !== 1'b0) begin bad++; $display("FAIL rstmid_status got=%0d/%0b/%0b exp=0/0/0", lvl_a, err_a, ovf_a); end
        ifa.char_ready = 1'b1;
        wait_cyc(3);
        clear_logs();
        send_char(1, 5'b00000, 40);
        total++; if (qa.size() < 1 || qa[0] !== 14) begin bad++; $display("FAIL rstmid_e got=%0d exp=14", (qa.size() > 0) ? qa[0] : -1); end
        total++; if (qa.size() !== 2) begin bad++; $display("FAIL rstmid_count got=%0d exp=2", qa.size()); end
    endtask

    task automatic test_active_low();
        clear_logs();
        use_b = 1'b1;
        send_char(2, 5'b00001, 40);
        use_b = 1'b0;
        total++; if (qb.size() < 1 || qb[0] !== 10) begin bad++; $display("FAIL actlow_code got=%0d exp=10", (qb.size() > 0) ? qb[0] : -1); end
        total++; if (qb.size() < 2 || qb[1] !== 36) begin bad++; $display("FAIL actlow_space got=%0d exp=36", (qb.size() > 1) ? qb[1] : -1); end
        total++; if (qb.size() !== 2 || err_cnt_b !== 0) begin bad++; $display("FAIL actlow_count got=%0d/%0d exp=2/0", qb.size(), err_cnt_b); end
        total++; if (qa.size() !== 0) begin bad++; $display("FAIL actlow_a_quiet got=%0d exp=0", qa.size()); end
    endtask

    task automatic test_ce_hold();
        clear_logs();
        key = 1'b1;
        wait_cyc(4);
        key = 1'b0;
        wait_cyc(6);
        ce = 1'b0;
        wait_cyc(50);
        total++; if (qa.size() !== 0 || lvl_a !== 4'd0) begin bad++; $display("FAIL ce_hold got=%0d/%0d exp=0/0", qa.size(), lvl_a); end
        ce = 1'b1;
        wait_cyc(40);
        total++; if (qa.size() < 1 || qa[0] !== 14) begin bad++; $display("FAIL ce_resume_code got=%0d exp=14", (qa.size() > 0) ? qa[0] : -1); end
        total++; if (qa.size() < 2 || qa[1] !== 36) begin bad++; $display("FAIL ce_resume_space got=%0d exp=36", (qa.size() > 1) ? qa[1] : -1); end
    endtask

    initial begin
        ifa.char_ready = 1'b1;
        ifb.char_ready = 1'b1;
        test_reset();
        test_letter_a();
        test_bad_mark();
        test_sym_overflow();
        test_fifo_overflow();
        test_reset_mid_char();
        test_active_low();
        test_ce_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
